// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential nibble-serial multiplier: FSM states,
// default operand width and per-partial shift amounts.
package mult_seq_pkg;

  localparam int unsigned OP_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Left shift applied to each partial product, in units of HALF bits.
  localparam int unsigned SH_LL = 0;
  localparam int unsigned SH_LH = 1;
  localparam int unsigned SH_HL = 1;
  localparam int unsigned SH_HH = 2;

endpackage

// File: rtl/mult_half_core.sv
// Combinational HALF x HALF unsigned multiplier; the one core shared by all
// four partial-product steps.
module mult_half_core #(
  parameter int unsigned HALF = 4
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  assign p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential OP_W x OP_W unsigned multiplier: one HALF-width core walks the
// ll/lh/hl/hh partials into an accumulator. Optional macro
// MULT8_SEQ_ZERO_SKIP_EN sends a zero operand straight from IDLE to DONE.
module mult8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_p,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int unsigned HALF = OP_W / 2;
  localparam int unsigned PW   = 2 * OP_W;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and a producer holding valid
  // keeps its data stable until the transfer.
  state_t          state_q, state_d;
  logic [OP_W-1:0] a_q, b_q;
  logic [PW-1:0]   acc_q, acc_d, out_q, term;
  logic [HALF-1:0] core_a, core_b;
  logic [OP_W-1:0] core_p;
  int unsigned     sh;
  logic            accept;

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    core_a = a_q[HALF-1:0];
    core_b = b_q[HALF-1:0];
    sh     = SH_LL;
    case (state_q)
      LH: begin
        core_b = b_q[OP_W-1:HALF];
        sh     = SH_LH;
      end
      HL: begin
        core_a = a_q[OP_W-1:HALF];
        sh     = SH_HL;
      end
      HH: begin
        core_a = a_q[OP_W-1:HALF];
        core_b = b_q[OP_W-1:HALF];
        sh     = SH_HH;
      end
      default: ;
    endcase
  end

  mult_half_core #(.HALF(HALF)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  assign term = {{OP_W{1'b0}}, core_p} << (sh * HALF);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
          state_d = ((in_a == '0) || (in_b == '0)) ? DONE : LL;
`else
          state_d = LL;
`endif
        end
      end
      LL: begin
        acc_d   = acc_q + term;
        state_d = LH;
      end
      LH: begin
        acc_d   = acc_q + term;
        state_d = HL;
      end
      HL: begin
        acc_d   = acc_q + term;
        state_d = HH;
      end
      HH: begin
        acc_d   = acc_q + term;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      // The product register only loads on entry to DONE, so it holds the
      // last result while the next operation accumulates.
      if ((state_d == DONE) && (state_q != DONE)) out_q <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = out_q;
  assign dbg_state = state_q;

endmodule
